uart_cmd_responder: RTL
=======================

Name: uart_cmd_responder

Overview:
- Command-level responder on the parallel side of the UART block, in the UART clock domain.
- Consumes received bytes (rx_data/rx_valid) and parses them as command frames.
- Executes writes and reads against an internal register file.
- Returns read data byte-by-byte through the UART transmitter's parallel handshake (tx_data/tx_valid/tx_busy).

Parameters:
- DATA_WIDTH, 8, width of a UART character and of each register.
- ADDR_WIDTH, 4, register file address width; depth = 2**ADDR_WIDTH.
- TIMEOUT_CYCLES, 1023, maximum cycles allowed between bytes of one frame before the frame is abandoned.

Ports:
- CLK  in  1  single clock, shared with the UART TX/RX.
- RST  in  1  asynchronous, active-high reset.
- rx_data  in  DATA_WIDTH  received byte.
- rx_valid  in  1  one-cycle strobe: rx_data is valid.
- rx_parity_error  in  1  qualifies rx_valid: byte is corrupt.
- rx_framing_error  in  1  qualifies rx_valid: byte is corrupt.
- tx_data  out  DATA_WIDTH  byte to transmit.
- tx_valid  out  1  one-cycle transmit request.
- tx_busy  in  1  transmitter busy flag.
- reg0_out  out  DATA_WIDTH  live contents of register 0 (configuration).
- reg1_out  out  DATA_WIDTH  live contents of register 1 (configuration).
- frame_error  out  1  one-cycle pulse: frame abandoned (corrupt byte, timeout, or unknown opcode).
- overrun  out  1  sticky: an rx byte was dropped while responding; cleared only by RST.

Behaviour:
- Reset (async assert): all registers 0, state IDLE, tx_data=0, tx_valid=0, frame_error=0, overrun=0.
- Frame formats (byte order on the wire):
  - WRITE: 0xAA, addr, data.
  - READ: 0xBB, addr. Response: 1 byte.
  - BURST: 0xCC, addr, count. Response: count bytes, addresses addr, addr+1, ...
  - addr uses the low ADDR_WIDTH bits; upper bits are ignored.
  - Burst address increments modulo depth (wraps 2**ADDR_WIDTH-1 -> 0).
  - count=0: no response, return to IDLE.
- Byte acceptance: a byte is accepted only on rx_valid=1 with both error inputs 0.
  - rx_valid with either error input set: frame_error pulse, return to IDLE. In IDLE this only pulses frame_error.
- States:
  - IDLE: on accepted byte: 0xAA -> W_ADDR; 0xBB -> R_ADDR; 0xCC -> B_ADDR; any other value -> frame_error pulse, stay IDLE.
  - W_ADDR -> W_DATA: latch addr.
  - W_DATA: register write takes effect the cycle after the data byte is accepted; -> IDLE. No response byte.
  - R_ADDR: latch addr, remaining=1 -> TX_REQ.
  - B_ADDR -> B_CNT: latch addr.
  - B_CNT: latch remaining=count; count=0 -> IDLE, else -> TX_REQ.
  - TX_REQ: when tx_busy=0, drive tx_data=regfile[addr], pulse tx_valid for exactly one cycle -> TX_WAIT_HI.
  - TX_WAIT_HI: wait for tx_busy=1 -> TX_WAIT_LO.
  - TX_WAIT_LO: wait for tx_busy=0; then addr+1, remaining-1; remaining now 0 -> IDLE, else -> TX_REQ.
- tx_data holds its value from the tx_valid cycle until the next request.
- Inter-byte timeout: a counter runs in W_ADDR, W_DATA, R_ADDR, B_ADDR and B_CNT; it resets on each accepted byte. On reaching TIMEOUT_CYCLES: frame_error pulse, -> IDLE, no write performed.
- Overrun: rx_valid in any TX_* state drops the byte and sets overrun.
- Read data is sampled at TX_REQ issue, so a burst reflects the current register contents.
- Same-cycle rx_valid and timeout expiry: the byte is accepted and the timeout is ignored.
- Reset mid-frame or mid-response: immediate abort to reset values; a tx byte already handed to the transmitter is not tracked.

Decomposition:
- Shared package uart_cmd_pkg:
  - opcode constants OP_WRITE=8'hAA, OP_READ=8'hBB, OP_BURST=8'hCC.
  - state enumeration.
- One sub-module: uart_cmd_regfile (depth 2**ADDR_WIDTH x DATA_WIDTH, 1 write port, 1 async read port, async active-high reset, reg0/reg1 taps).
- The parser FSM, timeout counter and TX handshake stay in the top module.

Test Plan:
- Write then read:
  - Send AA 03 5A, then BB 03 -> exactly one tx_valid pulse with tx_data=0x5A.
  - Send AA 00 C3 -> reg0_out=0xC3.
- Burst wrap:
  - Preload regs E,F,0 with 11,22,33; send CC 0E 03 -> three tx_valid pulses, data 11,22,33.
  - Each pulse is issued only after tx_busy has gone high then low following the previous one.
- Burst count 0: send CC 05 00 -> no tx_valid; the next BB 05 is answered normally.
- Corrupt and unknown bytes:
  - Send AA, then 03 with rx_parity_error=1 -> frame_error pulse, no write.
  - A following 0x7E in IDLE -> frame_error pulse; state stays IDLE.
- Timeout: send AA 02, then idle for TIMEOUT_CYCLES -> frame_error pulse; a later 77 is parsed as an opcode (unknown) -> second frame_error pulse; reg2 unchanged.
- Overrun and reset:
  - Inject rx_valid during TX_WAIT_LO -> overrun=1 and held; the response completes unaffected.
  - Assert RST mid-burst -> all outputs 0 asynchronously; regfile cleared.

Source files
------------

// File: rtl/uart_cmd_pkg.sv
// Shared opcode constants and parser state encoding for the UART command responder.
package uart_cmd_pkg;

  localparam logic [7:0] OP_WRITE = 8'hAA;
  localparam logic [7:0] OP_READ  = 8'hBB;
  localparam logic [7:0] OP_BURST = 8'hCC;

  typedef enum logic [3:0] {
    IDLE,
    W_ADDR,
    W_DATA,
    R_ADDR,
    B_ADDR,
    B_CNT,
    TX_REQ,
    TX_WAIT_HI,
    TX_WAIT_LO
  } state_t;

endpackage

// File: rtl/uart_cmd_regfile.sv
// Register file: one write port, one combinational read port, reg0/reg1 exposed live.
module uart_cmd_regfile #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic [DATA_WIDTH-1:0] reg0,
  output logic [DATA_WIDTH-1:0] reg1
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Per-entry flops so the whole file clears on reset.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
        mem[gi] <= '0;
      end else if (we && (waddr == ADDR_WIDTH'(gi))) begin
        mem[gi] <= wdata;
      end
    end
  end

  assign rdata = mem[raddr];
  assign reg0  = mem[0];
  assign reg1  = mem[1];

endmodule

// File: rtl/uart_cmd_responder.sv
// Parses UART command frames (write / read / burst read), drives the register file
// and streams read data back through the transmitter's valid/busy handshake.
module uart_cmd_responder
  import uart_cmd_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int ADDR_WIDTH     = 4,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] rx_data,
  input  logic                  rx_valid,
  input  logic                  rx_parity_error,
  input  logic                  rx_framing_error,
  output logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx_valid,
  input  logic                  tx_busy,
  output logic [DATA_WIDTH-1:0] reg0_out,
  output logic [DATA_WIDTH-1:0] reg1_out,
  output logic                  frame_error,
  output logic                  overrun
);

  localparam int TW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

  state_t                state;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] remaining;
  logic [TW-1:0]         timer;
  logic [DATA_WIDTH-1:0] rdata;

  logic accept, corrupt, in_frame, expire, we;

  assign accept   = rx_valid && !rx_parity_error && !rx_framing_error;
  assign corrupt  = rx_valid && (rx_parity_error || rx_framing_error);
  assign in_frame = state inside {W_ADDR, W_DATA, R_ADDR, B_ADDR, B_CNT};
  assign expire   = in_frame && (timer == TIMER_LAST);
  assign we       = (state == W_DATA) && accept;

  uart_cmd_regfile #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_regfile (
    .CLK  (CLK),
    .RST  (RST),
    .we   (we),
    .waddr(addr),
    .wdata(rx_data),
    .raddr(addr),
    .rdata(rdata),
    .reg0 (reg0_out),
    .reg1 (reg1_out)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state       <= IDLE;
      addr        <= '0;
      remaining   <= '0;
      timer       <= '0;
      tx_data     <= '0;
      tx_valid    <= 1'b0;
      frame_error <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      tx_valid    <= 1'b0;
      frame_error <= 1'b0;

      // Inter-byte timer only runs while a frame is half received.
      if (!in_frame || accept) timer <= '0;
      else                     timer <= timer + 1'b1;

      if (in_frame) begin
        if (corrupt) begin
          frame_error <= 1'b1;
          state       <= IDLE;
        end else if (accept) begin
          case (state)
            W_ADDR: begin
              addr  <= rx_data[ADDR_WIDTH-1:0];
              state <= W_DATA;
            end
            W_DATA: state <= IDLE;
            R_ADDR: begin
              addr      <= rx_data[ADDR_WIDTH-1:0];
              remaining <= DATA_WIDTH'(1);
              state     <= TX_REQ;
            end
            B_ADDR: begin
              addr  <= rx_data[ADDR_WIDTH-1:0];
              state <= B_CNT;
            end
            default: begin
              remaining <= rx_data;
              state     <= (rx_data == '0) ? IDLE : TX_REQ;
            end
          endcase
        end else if (expire) begin
          frame_error <= 1'b1;
          state       <= IDLE;
        end
      end else begin
        case (state)
          IDLE: begin
            if (corrupt) begin
              frame_error <= 1'b1;
            end else if (accept) begin
              if (rx_data == DATA_WIDTH'(OP_WRITE))      state <= W_ADDR;
              else if (rx_data == DATA_WIDTH'(OP_READ))  state <= R_ADDR;
              else if (rx_data == DATA_WIDTH'(OP_BURST)) state <= B_ADDR;
              else frame_error <= 1'b1;
            end
          end
          TX_REQ: begin
            if (!tx_busy) begin
              tx_data  <= rdata;
              tx_valid <= 1'b1;
              state    <= TX_WAIT_HI;
            end
          end
          TX_WAIT_HI: begin
            if (tx_busy) state <= TX_WAIT_LO;
          end
          TX_WAIT_LO: begin
            if (!tx_busy) begin
              addr      <= addr + 1'b1;
              remaining <= remaining - 1'b1;
              state     <= (remaining == DATA_WIDTH'(1)) ? IDLE : TX_REQ;
            end
          end
          default: state <= IDLE;
        endcase

        // Bytes arriving while a response is in flight are dropped.
        if ((state inside {TX_REQ, TX_WAIT_HI, TX_WAIT_LO}) && rx_valid) overrun <= 1'b1;
      end
    end
  end

endmodule
